// File: rtl/simple_processor_pkg.sv
// Shared types and constants for simple_processor, including the load/store unit.
package simple_processor_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    FUNC_NONE  = 2'd0,
    FUNC_LOAD  = 2'd1,
    FUNC_STORE = 2'd2,
    FUNC_OTHER = 2'd3
  } func_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_FUNC     = 2'd3
  } err_t;

  typedef enum logic [1:0] {
    LSU_IDLE     = 2'd0,
    LSU_WAIT_ACK = 2'd1,
    LSU_RESP     = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store byte enables and data
// shifted into lanes, and load data extracted from a lane and extended.
module lsu_align
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_BITS  = $clog2(DATA_WIDTH / 8)
) (
  input  mem_size_t                st_size,
  input  logic [LANE_BITS-1:0]     st_lane,
  input  logic [DATA_WIDTH-1:0]    st_data,
  output logic [DATA_WIDTH/8-1:0]  be,
  output logic [DATA_WIDTH-1:0]    wdata,
  input  mem_size_t                ld_size,
  input  logic [LANE_BITS-1:0]     ld_lane,
  input  logic                     ld_unsigned,
  input  logic [DATA_WIDTH-1:0]    rdata,
  output logic [DATA_WIDTH-1:0]    ld_data
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] MASK8  = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] MASK16 = DATA_WIDTH'(16'hFFFF);
  localparam logic [DATA_WIDTH-1:0] MASK32 = DATA_WIDTH'(32'hFFFF_FFFF);

  logic [BE_W-1:0]       be_base;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] mask;
  logic                  sign;

  // Store path: pick the enable pattern for the access size and move it and the data to the lane.
  always_comb begin
    be_base = BE_W'(4'hF);
    case (st_size)
      SZ_BYTE: be_base = BE_W'(1);
      SZ_HALF: be_base = BE_W'(3);
      default: be_base = BE_W'(4'hF);
    endcase
    be    = be_base << st_lane;
    wdata = st_data << {st_lane, 3'b000};
  end

  // Load path: bring the addressed lane down to bit 0, keep the access width, then extend.
  always_comb begin
    shifted = rdata >> {ld_lane, 3'b000};
    mask    = MASK32;
    sign    = shifted[31];
    case (ld_size)
      SZ_BYTE: begin mask = MASK8;  sign = shifted[7];  end
      SZ_HALF: begin mask = MASK16; sign = shifted[15]; end
      default: begin mask = MASK32; sign = shifted[31]; end
    endcase
    ld_data = (shifted & mask) | ((sign && !ld_unsigned) ? ~mask : '0);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit: accepts one request, runs a req/ack DMEM
// transaction with a timeout, and reports completion with a one-cycle done pulse.
module lsu_ctrl
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH     = simple_processor_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  func_t                    func_i,
  input  mem_size_t                size_i,
  input  logic                     unsigned_i,
  input  logic [DATA_WIDTH-1:0]    rs1_data_i,
  input  logic [DATA_WIDTH-1:0]    offset_i,
  input  logic [DATA_WIDTH-1:0]    rs2_data_i,
  output logic                     done_o,
  output err_t                     err_o,
  output logic [DATA_WIDTH-1:0]    rd_data_o,
  output logic                     dmem_req_o,
  output logic [ADDR_WIDTH-1:0]    dmem_addr_o,
  output logic                     dmem_we_o,
  output logic [DATA_WIDTH/8-1:0]  dmem_be_o,
  output logic [DATA_WIDTH-1:0]    dmem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata_i,
  input  logic                     dmem_ack_i
);

  localparam int BE_W      = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BE_W);
  localparam int CNT_W     = $clog2(TIMEOUT_CYCLES);

  lsu_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] sum;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  misalign;
  logic                  bad_func;
  logic [BE_W-1:0]       be_new;
  logic [DATA_WIDTH-1:0] wdata_new;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  timeout_hit;

  logic [ADDR_WIDTH-1:0] addr_q;
  mem_size_t             size_q;
  logic                  unsigned_q;
  func_t                 func_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_W-1:0]       be_q;
  err_t                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0]      cnt_q;

  assign sum         = rs1_data_i + offset_i;
  assign req_addr    = sum[ADDR_WIDTH-1:0];
  assign misalign    = ((size_i == SZ_HALF) && req_addr[0]) ||
                       ((size_i != SZ_BYTE) && (size_i != SZ_HALF) && (req_addr[1:0] != 2'b00));
  assign bad_func    = (func_i != FUNC_LOAD) && (func_i != FUNC_STORE);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANE_BITS  (LANE_BITS)
  ) u_align (
    .st_size     (size_i),
    .st_lane     (req_addr[LANE_BITS-1:0]),
    .st_data     (rs2_data_i),
    .be          (be_new),
    .wdata       (wdata_new),
    .ld_size     (size_q),
    .ld_lane     (addr_q[LANE_BITS-1:0]),
    .ld_unsigned (unsigned_q),
    .rdata       (rdata_q),
    .ld_data     (ld_data)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= LSU_IDLE;
    else       state_q <= state_d;
  end

  // Request capture, timeout counter, read-data capture and error latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      func_q     <= FUNC_NONE;
      wdata_q    <= '0;
      be_q       <= '0;
      err_q      <= ERR_NONE;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          cnt_q <= '0;
          if (valid_i) begin
            addr_q     <= req_addr;
            size_q     <= size_i;
            unsigned_q <= unsigned_i;
            func_q     <= func_i;
            wdata_q    <= wdata_new;
            be_q       <= be_new;
            rdata_q    <= '0;
            if (misalign)      err_q <= ERR_MISALIGN;
            else if (bad_func) err_q <= ERR_FUNC;
            else               err_q <= ERR_NONE;
          end
        end
        LSU_WAIT_ACK: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (dmem_ack_i)       rdata_q <= dmem_rdata_i;
          else if (timeout_hit) err_q   <= ERR_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and all outputs; DMEM lines are only driven while a request is open.
  always_comb begin
    state_d      = state_q;
    ready_o      = 1'b0;
    done_o       = 1'b0;
    err_o        = ERR_NONE;
    rd_data_o    = '0;
    dmem_req_o   = 1'b0;
    dmem_addr_o  = '0;
    dmem_we_o    = 1'b0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    case (state_q)
      LSU_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = (misalign || bad_func) ? LSU_RESP : LSU_WAIT_ACK;
      end
      LSU_WAIT_ACK: begin
        dmem_req_o   = 1'b1;
        dmem_addr_o  = {addr_q[ADDR_WIDTH-1:LANE_BITS], LANE_BITS'(0)};
        dmem_we_o    = (func_q == FUNC_STORE);
        dmem_be_o    = be_q;
        dmem_wdata_o = wdata_q;
        if (dmem_ack_i || timeout_hit) state_d = LSU_RESP;
      end
      LSU_RESP: begin
        done_o = 1'b1;
        err_o  = err_q;
        if ((func_q == FUNC_LOAD) && (err_q == ERR_NONE)) rd_data_o = ld_data;
        state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with hand-computed expectations.
module tb_lsu_ctrl;
  import simple_processor_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  func_t       func_i = FUNC_NONE;
  mem_size_t   size_i = SZ_BYTE;
  logic        unsigned_i = 1'b0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] offset_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        done_o;
  err_t        err_o;
  logic [31:0] rd_data_o;
  logic        dmem_req_o;
  logic [31:0] dmem_addr_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i = '0;
  logic        dmem_ack_i = 1'b0;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .func_i       (func_i),
    .size_i       (size_i),
    .unsigned_i   (unsigned_i),
    .rs1_data_i   (rs1_data_i),
    .offset_i     (offset_i),
    .rs2_data_i   (rs2_data_i),
    .done_o       (done_o),
    .err_o        (err_o),
    .rd_data_o    (rd_data_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_rdata_i (dmem_rdata_i),
    .dmem_ack_i   (dmem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one request for a single accepting clock edge, then drop valid.
  task automatic applyStimulus(input func_t f, input mem_size_t s, input logic u,
                               input logic [31:0] rs1, input logic [31:0] off,
                               input logic [31:0] rs2);
    @(negedge clk_i);
    func_i = f; size_i = s; unsigned_i = u;
    rs1_data_i = rs1; offset_i = off; rs2_data_i = rs2;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
  endtask

  // Complete an open DMEM request in its first cycle and check the response.
  task automatic ackAndCheck(input string tag, input logic [31:0] rdata,
                             input logic [31:0] exp_rd);
    dmem_ack_i = 1'b1;
    dmem_rdata_i = rdata;
    @(negedge clk_i);
    dmem_ack_i = 1'b0;
    checkOutput({tag, "_done"}, done_o, 1);
    checkOutput({tag, "_err"}, err_o, ERR_NONE);
    checkOutput({tag, "_rd"}, rd_data_o, exp_rd);
    checkOutput({tag, "_req_drop"}, dmem_req_o, 0);
    @(negedge clk_i);
    checkOutput({tag, "_done_pulse"}, done_o, 0);
    checkOutput({tag, "_ready"}, ready_o, 1);
  endtask

  initial begin
    int n;
    $display("[TB] start");
    repeat (3) @(negedge clk_i);
    checkOutput("rst_ready", ready_o, 1);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_err", err_o, ERR_NONE);
    checkOutput("rst_rd", rd_data_o, 0);
    checkOutput("rst_dmem", {dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o}, 0);
    checkOutput("rst_wdata", dmem_wdata_o, 0);
    rst_i = 1'b0;

    // LOAD WORD 0x100+4
    applyStimulus(FUNC_LOAD, SZ_WORD, 1'b0, 32'h100, 32'h4, 32'h0);
    @(negedge clk_i);
    checkOutput("lw_req", dmem_req_o, 1);
    checkOutput("lw_addr", dmem_addr_o, 32'h104);
    checkOutput("lw_be", dmem_be_o, 4'hF);
    checkOutput("lw_we", dmem_we_o, 0);
    checkOutput("lw_busy", {ready_o, done_o}, 2'b00);
    ackAndCheck("lw", 32'hDEADBEEF, 32'hDEADBEEF);

    // LOAD BYTE signed at 0x203
    applyStimulus(FUNC_LOAD, SZ_BYTE, 1'b0, 32'h200, 32'h3, 32'h0);
    @(negedge clk_i);
    checkOutput("lb_be", dmem_be_o, 4'b1000);
    checkOutput("lb_addr", dmem_addr_o, 32'h200);
    ackAndCheck("lb", 32'h8000_0000, 32'hFFFF_FF80);

    // LOAD BYTE unsigned at 0x203
    applyStimulus(FUNC_LOAD, SZ_BYTE, 1'b1, 32'h200, 32'h3, 32'h0);
    @(negedge clk_i);
    ackAndCheck("lbu", 32'h8000_0000, 32'h0000_0080);

    // LOAD HALF signed at lane 2
    applyStimulus(FUNC_LOAD, SZ_HALF, 1'b0, 32'h10, 32'hFFFF_FFF6, 32'h0);
    @(negedge clk_i);
    checkOutput("lh_addr", dmem_addr_o, 32'h4);
    checkOutput("lh_be", dmem_be_o, 4'b1100);
    ackAndCheck("lh", 32'h8001_1234, 32'hFFFF_8001);

    // STORE HALF at 0x102
    applyStimulus(FUNC_STORE, SZ_HALF, 1'b0, 32'h100, 32'h2, 32'h1234_ABCD);
    @(negedge clk_i);
    checkOutput("sh_we", dmem_we_o, 1);
    checkOutput("sh_be", dmem_be_o, 4'b1100);
    checkOutput("sh_wdata", dmem_wdata_o, 32'hABCD_0000);
    ackAndCheck("sh", 32'hFFFF_FFFF, 32'h0);

    // STORE BYTE with address wrap: 0xFFFFFFFC + 5 -> 0x1
    applyStimulus(FUNC_STORE, SZ_BYTE, 1'b0, 32'hFFFF_FFFC, 32'h5, 32'h0000_00A5);
    @(negedge clk_i);
    checkOutput("sb_wrap_addr", dmem_addr_o, 32'h0);
    checkOutput("sb_be", dmem_be_o, 4'b0010);
    checkOutput("sb_wdata", dmem_wdata_o, 32'h0000_A500);
    ackAndCheck("sb", 32'h0, 32'h0);

    // LOAD HALF misaligned: no DMEM access, immediate response
    applyStimulus(FUNC_LOAD, SZ_HALF, 1'b0, 32'h100, 32'h1, 32'h0);
    @(negedge clk_i);
    checkOutput("mis_req", dmem_req_o, 0);
    checkOutput("mis_done", done_o, 1);
    checkOutput("mis_err", err_o, ERR_MISALIGN);
    checkOutput("mis_rd", rd_data_o, 0);
    @(negedge clk_i);
    checkOutput("mis_ready", {ready_o, done_o}, 2'b10);

    // Unsupported function, aligned
    applyStimulus(FUNC_OTHER, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h0);
    @(negedge clk_i);
    checkOutput("func_req", dmem_req_o, 0);
    checkOutput("func_err", {done_o, err_o}, {1'b1, ERR_FUNC});

    // Unsupported function and misaligned: misalign wins
    applyStimulus(FUNC_OTHER, SZ_WORD, 1'b0, 32'h102, 32'h0, 32'h0);
    @(negedge clk_i);
    checkOutput("prio_err", {done_o, err_o}, {1'b1, ERR_MISALIGN});

    // Timeout: request stays open for exactly 16 cycles
    applyStimulus(FUNC_LOAD, SZ_WORD, 1'b0, 32'h300, 32'h0, 32'h0);
    @(negedge clk_i);
    n = 0;
    while (dmem_req_o && n < 40) begin
      n++;
      @(negedge clk_i);
    end
    checkOutput("to_cycles", n, 16);
    checkOutput("to_err", {done_o, err_o}, {1'b1, ERR_TIMEOUT});
    checkOutput("to_rd", rd_data_o, 0);

    // Reset in WAIT_ACK, followed by a late ack
    applyStimulus(FUNC_LOAD, SZ_WORD, 1'b0, 32'h400, 32'h0, 32'h0);
    @(negedge clk_i);
    checkOutput("rw_req", dmem_req_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("rw_req_drop", dmem_req_o, 0);
    checkOutput("rw_state", {ready_o, done_o}, 2'b10);
    rst_i = 1'b0;
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    dmem_ack_i = 1'b0;
    checkOutput("rw_late_ack", {ready_o, done_o, dmem_req_o}, 3'b100);
    @(negedge clk_i);
    checkOutput("rw_idle", {ready_o, done_o}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
